// File: rtl/axi_ram_read_port.sv
// AXI4 read-only slave in front of a word-wide RAM, preloaded through a native byte-strobed port.
// One beat per cycle into a READ_LATENCY-deep read pipeline, drained through a credit-limited output buffer.
module axi_ram_read_port #(
   parameter int MEMORY_SIZE_BYTES = 4096,
   parameter int AXI_DATA_WIDTH    = 64,
   parameter int AXI_ID_WIDTH      = 8,
   parameter int AXI_ADDR_WIDTH    = 32,
   parameter int READ_LATENCY      = 1
) (
   input  logic                                                 axi_clk,
   input  logic                                                 axi_resetn,
   input  logic [AXI_ADDR_WIDTH-1:0]                            axi_ar_addr,
   input  logic [1:0]                                           axi_ar_burst,
   input  logic [2:0]                                           axi_ar_size,
   input  logic [AXI_ID_WIDTH-1:0]                              axi_ar_id,
   input  logic [7:0]                                           axi_ar_len,
   input  logic                                                 axi_ar_valid,
   output logic                                                 axi_ar_ready,
   output logic [AXI_DATA_WIDTH-1:0]                            axi_r_data,
   output logic [AXI_ID_WIDTH-1:0]                              axi_r_id,
   output logic [1:0]                                           axi_r_resp,
   output logic                                                 axi_r_last,
   output logic                                                 axi_r_valid,
   input  logic                                                 axi_r_ready,
   input  logic                                                 load_we,
   input  logic [$clog2(MEMORY_SIZE_BYTES*8/AXI_DATA_WIDTH)-1:0] load_addr,
   input  logic [AXI_DATA_WIDTH-1:0]                            load_data,
   input  logic [AXI_DATA_WIDTH/8-1:0]                          load_strb
);

   localparam int WORD_BYTES = AXI_DATA_WIDTH / 8;
   localparam int OFFS       = $clog2(WORD_BYTES);
   localparam int MEM_AW     = $clog2(MEMORY_SIZE_BYTES);
   localparam int WORDS      = MEMORY_SIZE_BYTES / WORD_BYTES;
   localparam int WADDR      = $clog2(WORDS);
   localparam int DEPTH      = READ_LATENCY + 1;
   localparam int PW         = $clog2(DEPTH);
   localparam int CW         = $clog2(DEPTH + 1);
   localparam logic [2:0] MAX_SIZE = 3'(OFFS);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t                      r_state, w_state_nxt;
   logic                        r_rst_done;

   logic [AXI_ADDR_WIDTH-1:0]   r_addr;
   logic [7:0]                  r_len;
   logic [7:0]                  r_beat;
   logic [2:0]                  r_size;
   logic [1:0]                  r_burst;
   logic [AXI_ID_WIDTH-1:0]     r_id;
   logic                        r_berr;

   logic [AXI_ADDR_WIDTH-1:0]   w_incr;
   logic [AXI_ADDR_WIDTH-1:0]   w_wrap_mask;
   logic [AXI_ADDR_WIDTH-1:0]   w_addr_sum;
   logic [AXI_ADDR_WIDTH-1:0]   w_addr_nxt;
   logic                        w_beat_err;
   logic                        w_ar_err;
   logic                        w_ar_hs;
   logic                        w_issue;
   logic                        w_last_beat;
   logic                        w_last_issue;
   logic                        w_credit;
   logic                        w_pop;
   logic                        w_push;
   logic [CW:0]                 w_occ_eff;
   logic [WADDR-1:0]            w_waddr;

   logic [CW-1:0]               r_occ;

   logic [AXI_DATA_WIDTH-1:0]   r_mem   [WORDS];
   logic                        r_pv    [READ_LATENCY];
   logic                        r_perr  [READ_LATENCY];
   logic                        r_plast [READ_LATENCY];
   logic [AXI_ID_WIDTH-1:0]     r_pid   [READ_LATENCY];
   logic [AXI_DATA_WIDTH-1:0]   r_pdata [READ_LATENCY];

   logic [AXI_DATA_WIDTH-1:0]   r_fdata [DEPTH];
   logic [AXI_ID_WIDTH-1:0]     r_fid   [DEPTH];
   logic [1:0]                  r_fresp [DEPTH];
   logic                        r_flast [DEPTH];
   logic [PW-1:0]               r_wr_ptr;
   logic [PW-1:0]               r_rd_ptr;
   logic [CW-1:0]               r_count;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // ---------------- burst address generator ----------------
   assign w_incr      = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1} << r_size;
   assign w_wrap_mask = ((AXI_ADDR_WIDTH'(r_len) + {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1}) << r_size)
                        - {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1};
   assign w_addr_sum  = r_addr + w_incr;

   always_comb begin
      w_addr_nxt = w_addr_sum;
      case (r_burst)
         2'b00:   w_addr_nxt = r_addr;
         2'b10:   w_addr_nxt = (r_addr & ~w_wrap_mask) | (w_addr_sum & w_wrap_mask);
         default: w_addr_nxt = w_addr_sum;
      endcase
   end

   assign w_ar_err   = (axi_ar_burst == 2'b11)
                     || ((axi_ar_burst == 2'b10) && !((axi_ar_len == 8'd1) || (axi_ar_len == 8'd3)
                                                   || (axi_ar_len == 8'd7) || (axi_ar_len == 8'd15)))
                     || (axi_ar_size > MAX_SIZE);
   assign w_beat_err = r_berr || (|r_addr[AXI_ADDR_WIDTH-1:MEM_AW]);
   assign w_waddr    = r_addr[MEM_AW-1:OFFS];

   // Credit counts beats issued but not yet popped, so the buffer can never overflow.
   assign w_pop       = axi_r_valid && axi_r_ready;
   assign w_occ_eff   = {1'b0, r_occ} - {{CW{1'b0}}, w_pop};
   assign w_credit    = w_occ_eff < (CW+1)'(DEPTH);
   assign w_issue     = (r_state == S_BURST) && w_credit;
   assign w_last_beat = (r_beat == r_len);
   assign w_last_issue = w_issue && w_last_beat;

   always_comb begin
      w_state_nxt  = r_state;
      axi_ar_ready = r_rst_done && ((r_state == S_IDLE) || w_last_issue);
      w_ar_hs      = axi_ar_valid && axi_ar_ready;
      if (w_ar_hs)
         w_state_nxt = S_BURST;
      else if (w_last_issue)
         w_state_nxt = S_IDLE;
   end

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_state    <= S_IDLE;
         r_rst_done <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rst_done <= 1'b1;
      end
   end

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_addr  <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_id    <= '0;
         r_berr  <= 1'b0;
      end else if (w_ar_hs) begin
         r_addr  <= axi_ar_addr;
         r_len   <= axi_ar_len;
         r_beat  <= '0;
         r_size  <= axi_ar_size;
         r_burst <= axi_ar_burst;
         r_id    <= axi_ar_id;
         r_berr  <= w_ar_err;
      end else if (w_issue) begin
         r_addr  <= w_addr_nxt;
         r_beat  <= r_beat + 8'd1;
      end
   end

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn)
         r_occ <= '0;
      else
         r_occ <= r_occ + CW'(w_issue) - CW'(w_pop);
   end

   // ---------------- RAM and read pipeline ----------------
   // Read and write share the edge, so a colliding read sees the pre-write word.
   always_ff @(posedge axi_clk) begin
      if (load_we) begin
         for (int unsigned b = 0; b < WORD_BYTES; b++) begin
            if (load_strb[b])
               r_mem[load_addr][b*8 +: 8] <= load_data[b*8 +: 8];
         end
      end
      r_pdata[0] <= r_mem[w_waddr];
      for (int unsigned i = 1; i < READ_LATENCY; i++)
         r_pdata[i] <= r_pdata[i-1];
   end

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            r_pv[i]    <= 1'b0;
            r_perr[i]  <= 1'b0;
            r_plast[i] <= 1'b0;
            r_pid[i]   <= '0;
         end
      end else begin
         r_pv[0]    <= w_issue;
         r_perr[0]  <= w_beat_err;
         r_plast[0] <= w_last_beat;
         r_pid[0]   <= r_id;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            r_pv[i]    <= r_pv[i-1];
            r_perr[i]  <= r_perr[i-1];
            r_plast[i] <= r_plast[i-1];
            r_pid[i]   <= r_pid[i-1];
         end
      end
   end

   // ---------------- output buffer ----------------
   assign w_push = r_pv[READ_LATENCY-1];

   always_ff @(posedge axi_clk) begin
      if (w_push) begin
         r_fdata[r_wr_ptr] <= r_perr[READ_LATENCY-1] ? '0 : r_pdata[READ_LATENCY-1];
         r_fresp[r_wr_ptr] <= r_perr[READ_LATENCY-1] ? 2'b10 : 2'b00;
         r_flast[r_wr_ptr] <= r_plast[READ_LATENCY-1];
         r_fid[r_wr_ptr]   <= r_pid[READ_LATENCY-1];
      end
   end

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Head entry is gated by valid so the bus reads all-zero whenever nothing is buffered.
   assign axi_r_valid = (r_count != '0);
   assign axi_r_data  = axi_r_valid ? r_fdata[r_rd_ptr] : '0;
   assign axi_r_id    = axi_r_valid ? r_fid[r_rd_ptr]   : '0;
   assign axi_r_resp  = axi_r_valid ? r_fresp[r_rd_ptr] : 2'b00;
   assign axi_r_last  = axi_r_valid && r_flast[r_rd_ptr];

endmodule

// File: tb/tb_axi_ram_read_port.sv
// Scoreboard bench for axi_ram_read_port: expected beats come from a plain-arithmetic burst model.
module tb_axi_ram_read_port;

   localparam int MEM = 4096;
   localparam int DW  = 64;
   localparam int IDW = 8;
   localparam int AW  = 32;
   localparam int RL  = 2;
   localparam int WB  = DW / 8;
   localparam int NW  = MEM / WB;
   localparam int LAW = $clog2(NW);

   typedef struct {
      logic [DW-1:0]  data;
      logic [IDW-1:0] id;
      logic [1:0]     resp;
      logic           last;
   } beat_t;

   logic            clk = 1'b0;
   logic            rstn;
   logic [AW-1:0]   ar_addr;
   logic [1:0]      ar_burst;
   logic [2:0]      ar_size;
   logic [IDW-1:0]  ar_id;
   logic [7:0]      ar_len;
   logic            ar_valid;
   logic            ar_ready;
   logic [DW-1:0]   r_data;
   logic [IDW-1:0]  r_id;
   logic [1:0]      r_resp;
   logic            r_last;
   logic            r_valid;
   logic            r_ready = 1'b1;
   logic            ld_we;
   logic [LAW-1:0]  ld_addr;
   logic [DW-1:0]   ld_data;
   logic [WB-1:0]   ld_strb;

   logic [DW-1:0]   mem_m [NW];
   beat_t           exp_q [$];
   int              checks = 0;
   int              errors = 0;
   bit              rand_ready = 1'b0;

   axi_ram_read_port #(
      .MEMORY_SIZE_BYTES(MEM),
      .AXI_DATA_WIDTH(DW),
      .AXI_ID_WIDTH(IDW),
      .AXI_ADDR_WIDTH(AW),
      .READ_LATENCY(RL)
   ) dut (
      .axi_clk(clk),
      .axi_resetn(rstn),
      .axi_ar_addr(ar_addr),
      .axi_ar_burst(ar_burst),
      .axi_ar_size(ar_size),
      .axi_ar_id(ar_id),
      .axi_ar_len(ar_len),
      .axi_ar_valid(ar_valid),
      .axi_ar_ready(ar_ready),
      .axi_r_data(r_data),
      .axi_r_id(r_id),
      .axi_r_resp(r_resp),
      .axi_r_last(r_last),
      .axi_r_valid(r_valid),
      .axi_r_ready(r_ready),
      .load_we(ld_we),
      .load_addr(ld_addr),
      .load_data(ld_data),
      .load_strb(ld_strb)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      r_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected beats derived directly from the AXI burst rules.
   task automatic push_expected(input logic [AW-1:0] a, input logic [1:0] b, input logic [2:0] sz,
                                input logic [7:0] ln, input logic [IDW-1:0] id);
      longint unsigned nb, total, base, ai, a64;
      bit berr;
      beat_t e;
      a64   = longint'(a);
      nb    = 64'd1 << sz;
      berr  = (b == 2'b11) || (nb > WB)
           || ((b == 2'b10) && !((ln == 8'd1) || (ln == 8'd3) || (ln == 8'd7) || (ln == 8'd15)));
      total = (longint'(ln) + 1) * nb;
      base  = (a64 / total) * total;
      for (int i = 0; i <= int'(ln); i++) begin
         case (b)
            2'b00:   ai = a64;
            2'b10:   ai = base + ((a64 - base + longint'(i) * nb) % total);
            default: ai = (a64 + longint'(i) * nb) & 64'hFFFF_FFFF;
         endcase
         e.id   = id;
         e.last = (i == int'(ln));
         if (berr || ai >= MEM) begin
            e.resp = 2'b10;
            e.data = '0;
         end else begin
            e.resp = 2'b00;
            e.data = mem_m[int'(ai / WB)];
         end
         exp_q.push_back(e);
      end
   endtask

   // Entered and left at posedge+1; returns one step after the AR handshake edge.
   task automatic send_ar(input logic [AW-1:0] a, input logic [1:0] b, input logic [2:0] sz,
                          input logic [7:0] ln, input logic [IDW-1:0] id);
      int n;
      ar_addr = a; ar_burst = b; ar_size = sz; ar_len = ln; ar_id = id; ar_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ar_ready && n < 1000);
      if (!ar_ready) begin
         checks++;
         errors++;
         $display("FAIL ar_handshake_timeout: got no ar_ready after %0d cycles, expected ready", n);
      end else begin
         push_expected(a, b, sz, ln, id);
      end
      @(posedge clk);
      #1;
      ar_valid = 1'b0;
   endtask

   task automatic load_word(input int w, input logic [DW-1:0] d, input logic [WB-1:0] s);
      ld_we = 1'b1; ld_addr = LAW'(w); ld_data = d; ld_strb = s;
      @(posedge clk);
      #1;
      ld_we = 1'b0;
      for (int k = 0; k < WB; k++)
         if (s[k]) mem_m[w][k*8 +: 8] = d[k*8 +: 8];
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every R handshake and checks stall stability.
   bit              stalled = 1'b0;
   logic [DW-1:0]   h_data;
   logic [IDW-1:0]  h_id;
   logic [1:0]      h_resp;
   logic            h_last;
   beat_t           m_e;

   always @(negedge clk) begin
      if (!rstn) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("stall_valid", 64'(r_valid), 64'd1);
            chk("stall_data", r_data, h_data);
            chk("stall_meta", {52'd0, r_id, r_resp, r_last}, {52'd0, h_id, h_resp, h_last});
         end
         if (r_valid && r_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data %h id %h resp %0d, expected no beat", r_data, r_id, r_resp);
            end else begin
               m_e = exp_q.pop_front();
               chk("r_data", r_data, m_e.data);
               chk("r_id", 64'(r_id), 64'(m_e.id));
               chk("r_resp", 64'(r_resp), 64'(m_e.resp));
               chk("r_last", 64'(r_last), 64'(m_e.last));
            end
         end
         stalled = r_valid && !r_ready;
         h_data = r_data; h_id = r_id; h_resp = r_resp; h_last = r_last;
      end
   end

   initial begin
      logic [1:0]     b;
      logic [2:0]     sz;
      logic [7:0]     ln;
      logic [AW-1:0]  a;
      logic [7:0]     wrap_lens [4];
      wrap_lens[0] = 8'd1; wrap_lens[1] = 8'd3; wrap_lens[2] = 8'd7; wrap_lens[3] = 8'd15;

      rstn = 1'b0; ar_valid = 1'b0; ar_addr = '0; ar_burst = '0; ar_size = '0; ar_len = '0; ar_id = '0;
      ld_we = 1'b0; ld_addr = '0; ld_data = '0; ld_strb = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_r_valid", 64'(r_valid), 64'd0);
      chk("rst_r_last", 64'(r_last), 64'd0);
      chk("rst_r_resp", 64'(r_resp), 64'd0);
      chk("rst_r_id", 64'(r_id), 64'd0);
      chk("rst_r_data", r_data, 64'd0);
      chk("rst_ar_ready", 64'(ar_ready), 64'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ar_ready_after_reset", 64'(ar_ready), 64'd1);
      @(posedge clk);
      #1;

      for (int w = 0; w < NW; w++)
         load_word(w, (w < 16) ? DW'(w) : {$urandom, $urandom}, '1);

      // INCR from 0, first-beat latency with an empty buffer.
      send_ar(32'h0, 2'b01, 3'd3, 8'd3, 8'h05);
      for (int k = 1; k <= RL + 2; k++) begin
         @(negedge clk);
         chk("first_valid_latency", 64'(r_valid), 64'(k == RL + 2));
      end
      @(posedge clk);
      #1;
      drain();

      send_ar(32'h30, 2'b10, 3'd3, 8'd3, 8'h11);
      send_ar(32'h30, 2'b10, 3'd3, 8'd2, 8'h12);
      send_ar(MEM - 16, 2'b01, 3'd3, 8'd3, 8'h13);
      send_ar(32'hFFFF_FFF8, 2'b01, 3'd3, 8'd2, 8'h14);
      send_ar(32'h48, 2'b00, 3'd3, 8'd2, 8'h15);
      send_ar(32'h40, 2'b11, 3'd3, 8'd1, 8'h16);
      send_ar(32'h40, 2'b01, 3'd4, 8'd1, 8'h17);
      send_ar(32'h40, 2'b01, 3'd1, 8'd5, 8'h18);
      drain();

      // Same-cycle load and read of word 100 must return the old contents.
      send_ar(32'h320, 2'b01, 3'd3, 8'd0, 8'h21);
      load_word(100, 64'hDEAD_BEEF_CAFE_F00D, '1);
      drain();
      load_word(100, 64'h1122_3344_5566_7788, 8'h0F);
      send_ar(32'h320, 2'b01, 3'd3, 8'd0, 8'h22);
      drain();

      rand_ready = 1'b1;
      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: b = 2'b01;
            4, 5, 6:    b = 2'b10;
            7, 8:       b = 2'b00;
            default:    b = 2'b11;
         endcase
         sz = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
         if (b == 2'b10 && $urandom_range(0, 4) != 0)
            ln = wrap_lens[$urandom_range(0, 3)];
         else
            ln = 8'($urandom_range(0, 15));
         a = ($urandom_range(0, 4) == 0) ? AW'(MEM - 64 + $urandom_range(0, 63)) : AW'($urandom_range(0, MEM - 1));
         send_ar(a, b, sz, ln, 8'($urandom));
      end
      drain();
      rand_ready = 1'b0;
      @(posedge clk);
      #1;

      // Reset while beat 2 of an 8-beat burst is on the bus.
      send_ar(32'h40, 2'b01, 3'd3, 8'd7, 8'h77);
      for (int k = 1; k <= RL + 3; k++) @(negedge clk);
      #2;
      rstn = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("reset_mid_burst_r_valid", 64'(r_valid), 64'd0);
      chk("reset_mid_burst_ar_ready", 64'(ar_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ar_ready_after_rerelease", 64'(ar_ready), 64'd1);
      @(posedge clk);
      #1;
      send_ar(32'h10, 2'b01, 3'd3, 8'd1, 8'h78);
      drain();
      repeat (20) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
